// File: rtl/implication_pkg.sv
// -----------------------------------------------------------------------------
// implication_pkg
// Shared definitions for the implication responder: the responder FSM state
// encoding, the largest supported latency and the default counter width.
// -----------------------------------------------------------------------------
package implication_pkg;

    // Largest antecedent-to-consequent distance the delay line supports.
    localparam int LATENCY_MAX   = 7;

    // Default width of the response / drop counters.
    localparam int CNT_W_DEFAULT = 16;

    // Width of the in-flight counter; holds 0..LATENCY_MAX.
    localparam int INFLIGHT_W    = 4;

    // IDLE    : nothing in flight, no suppression armed
    // PENDING : at least one response in flight, no suppression armed
    // ARMED   : the next response that falls due will be suppressed
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ARMED   = 2'd2
    } state_t;

endpackage

// File: rtl/resp_delay_line.sv
// -----------------------------------------------------------------------------
// resp_delay_line
// DEPTH-deep 1-bit shift register that delays an accepted request until its
// response is due. DEPTH = 0 degenerates to a wire (gated by reset so that
// nothing leaks out while reset is held).
//
// Ports
//   clk    : clock, shifts on the rising edge
//   rst_n  : asynchronous active-low clear of every stage
//   din    : accepted request entering the line
//   dout   : request reaching the end of the line (response due now)
// -----------------------------------------------------------------------------
module resp_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_wire
        // No storage in the zero-latency case; the clock is intentionally idle.
        logic unused_clk;
        assign unused_clk = clk;
        assign dout       = din && rst_n;
    end else begin : g_shift
        logic [DEPTH-1:0] taps;

        // NOTE: every stage is cleared on reset (not just a valid bit) because
        // a request caught in flight must never surface after reset releases.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                taps <= '0;
            end else begin
                // NOTE: non-blocking assignments let each stage take the value
                // its neighbour held before the edge, independent of order.
                taps[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    taps[i] <= taps[i-1];
                end
            end
        end

        assign dout = taps[DEPTH-1];
    end

endmodule

// File: rtl/implication_responder.sv
// -----------------------------------------------------------------------------
// implication_responder
// Answers every accepted request (antecedent && en) with a one-cycle
// consequent pulse LATENCY cycles later (LATENCY = 0: same cycle,
// combinationally). An inject_fail pulse arms suppression of the next
// response that falls due; suppressed responses are counted as drops.
//
// Parameters
//   LATENCY : request-to-response distance in cycles, 0..LATENCY_MAX
//   CNT_W   : width of resp_count / drop_count (both saturate)
//
// Ports
//   clk         : clock
//   rst_n       : asynchronous active-low reset, discards in-flight responses
//   antecedent  : request, sampled every rising edge
//   en          : request enable (does not cancel responses in flight)
//   inject_fail : arms suppression of the next due response (does not stack)
//   consequent  : response pulse
//   busy        : any response in flight
//   inflight    : number of scheduled, not yet emitted/dropped responses
//   resp_count  : responses emitted since reset
//   drop_count  : responses suppressed since reset
//
// Build option
//   IMPLICATION_RESPONDER_SVA_EN : compiles embedded assertions and covers.
// -----------------------------------------------------------------------------
module implication_responder
    import implication_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  antecedent,
    input  logic                  en,
    input  logic                  inject_fail,
    output logic                  consequent,
    output logic                  busy,
    output logic [INFLIGHT_W-1:0] inflight,
    output logic [CNT_W-1:0]      resp_count,
    output logic [CNT_W-1:0]      drop_count
);

    if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_latency_range
        $error("implication_responder: LATENCY must be 0..%0d", LATENCY_MAX);
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                  accept;
    logic                  due;
    logic                  armed;
    logic                  suppress;
    logic                  emit;
    logic [INFLIGHT_W-1:0] inflight_q;
    logic [INFLIGHT_W-1:0] inflight_d;
    state_t                state;
    state_t                state_next;

    assign accept = antecedent && en;

    resp_delay_line #(
        .DEPTH (LATENCY)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (accept),
        .dout  (due)
    );

    // A fail injected in the very cycle a response is due claims that response.
    assign armed      = (state == ARMED);
    assign suppress   = due && (armed || inject_fail);
    assign emit       = due && !suppress;
    assign consequent = emit;

    // Simultaneous accept and departure leave the count unchanged.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        inflight_d = inflight_q;
        if (accept && !due) begin
            inflight_d = inflight_q + 4'd1;
        end else if (!accept && due) begin
            inflight_d = inflight_q - 4'd1;
        end
    end

    // Suppression wins over a new inject_fail in the same cycle, so a second
    // pulse while armed never buys a second drop.
    always_comb begin
        state_next = state;
        if (suppress) begin
            state_next = (inflight_d != '0) ? PENDING : IDLE;
        end else if (inject_fail || armed) begin
            state_next = ARMED;
        end else begin
            state_next = (inflight_d != '0) ? PENDING : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            inflight_q <= '0;
            resp_count <= '0;
            drop_count <= '0;
        end else begin
            state      <= state_next;
            inflight_q <= inflight_d;
            if (emit && resp_count != CNT_MAX) begin
                resp_count <= resp_count + 1'b1;
            end
            if (suppress && drop_count != CNT_MAX) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0);

`ifdef IMPLICATION_RESPONDER_SVA_EN
    // An unarmed accept must come out LATENCY cycles later, unless a later
    // inject_fail claimed exactly that response.
    a_response: assert property (
        @(posedge clk) disable iff (!rst_n)
        (accept && !armed) |-> ##LATENCY (consequent || suppress)
    );

    // Each high cycle of consequent is backed by its own accept, so a pulse
    // can never be stretched beyond one cycle per request.
    if (LATENCY == 0) begin : g_sva_width0
        a_pulse_width: assert property (
            @(posedge clk) disable iff (!rst_n) consequent |-> accept
        );
    end else begin : g_sva_widthn
        a_pulse_width: assert property (
            @(posedge clk) disable iff (!rst_n) consequent |-> $past(accept, LATENCY)
        );
    end

    a_inflight_max: assert property (
        @(posedge clk) disable iff (!rst_n) inflight <= LATENCY
    );

    c_overlapping: cover property (
        @(posedge clk) disable iff (!rst_n) consequent && accept
    );
    c_non_overlapping: cover property (
        @(posedge clk) disable iff (!rst_n) consequent && !accept
    );
`endif

endmodule

// File: tb/tb_implication_responder.sv
// -----------------------------------------------------------------------------
// tb_implication_responder
// Six responder instances (LATENCY 0,1,2,3,4,7; the LATENCY=0 one with
// CNT_W=4) driven by directed tables and then random stimulus. A queue-based
// model of due times checks every instance on every cycle.
// -----------------------------------------------------------------------------
module tb_implication_responder;
    import implication_pkg::*;

    localparam int NI = 6;

    function automatic int lat_of(int i);
        case (i)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 4;
            default: return 7;
        endcase
    endfunction

    function automatic int cw_of(int i);
        return (i == 0) ? 4 : 16;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ant_a  [NI];
    logic        en_a   [NI];
    logic        inj_a  [NI];
    logic        cons_a [NI];
    logic        busy_a [NI];
    logic [3:0]  infl_a [NI];
    logic [15:0] rc_a   [NI];
    logic [15:0] dc_a   [NI];
    state_t      st_a   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic                 c_w;
        logic                 b_w;
        logic [3:0]           i_w;
        logic [cw_of(g)-1:0]  rc_w;
        logic [cw_of(g)-1:0]  dc_w;

        implication_responder #(
            .LATENCY (lat_of(g)),
            .CNT_W   (cw_of(g))
        ) u (
            .clk         (clk),
            .rst_n       (rst_n),
            .antecedent  (ant_a[g]),
            .en          (en_a[g]),
            .inject_fail (inj_a[g]),
            .consequent  (c_w),
            .busy        (b_w),
            .inflight    (i_w),
            .resp_count  (rc_w),
            .drop_count  (dc_w)
        );

        assign cons_a[g] = c_w;
        assign busy_a[g] = b_w;
        assign infl_a[g] = i_w;
        assign rc_a[g]   = 16'(rc_w);
        assign dc_a[g]   = 16'(dc_w);
        assign st_a[g]   = u.state;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, int inst, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s u%0d (lat %0d) t=%0t got %0d expected %0d",
                     name, inst, lat_of(inst), $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each accepted request is a due time in a queue.
    // Evaluated at the falling edge, when this cycle's inputs are stable.
    // ------------------------------------------------------------------
    int sched  [NI][$];
    bit m_arm  [NI];
    int m_resp [NI];
    int m_drop [NI];
    int mt = 0;

    always @(negedge clk) begin
        int     lat;
        int     cmax;
        bit     acc;
        bit     due;
        bit     sup;
        bit     exp_c;
        state_t exp_st;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                sched[i].delete();
                m_arm[i]  = 1'b0;
                m_resp[i] = 0;
                m_drop[i] = 0;
                check("rst_consequent", i, cons_a[i], 0);
                check("rst_inflight", i, infl_a[i], 0);
                check("rst_busy", i, busy_a[i], 0);
                check("rst_resp_count", i, rc_a[i], 0);
                check("rst_drop_count", i, dc_a[i], 0);
                check("rst_state", i, int'(st_a[i]), int'(IDLE));
            end else begin
                lat   = lat_of(i);
                cmax  = (1 << cw_of(i)) - 1;
                acc   = ant_a[i] && en_a[i];
                due   = (lat == 0) ? acc : (sched[i].size() > 0 && sched[i][0] == mt);
                sup   = due && (m_arm[i] || inj_a[i]);
                exp_c = due && !sup;
                if (m_arm[i])                exp_st = ARMED;
                else if (sched[i].size() > 0) exp_st = PENDING;
                else                          exp_st = IDLE;

                check("consequent", i, cons_a[i], exp_c);
                check("inflight", i, infl_a[i], sched[i].size());
                check("busy", i, busy_a[i], sched[i].size() != 0);
                check("resp_count", i, rc_a[i], m_resp[i]);
                check("drop_count", i, dc_a[i], m_drop[i]);
                check("state", i, int'(st_a[i]), int'(exp_st));

                if (lat > 0 && due) void'(sched[i].pop_front());
                if (lat > 0 && acc) sched[i].push_back(mt + lat);
                if (sup)           m_arm[i] = 1'b0;
                else if (inj_a[i]) m_arm[i] = 1'b1;
                if (exp_c && m_resp[i] < cmax) m_resp[i]++;
                if (sup && m_drop[i] < cmax)   m_drop[i]++;
            end
        end
        mt++;
    end

    // ------------------------------------------------------------------
    // Directed scenarios; bit c of each mask refers to cycle c after reset
    // release (cycle 1 ends at the first rising edge with rst_n high).
    // ------------------------------------------------------------------
    typedef struct {
        int          inst;
        int          ncyc;
        logic [31:0] ant;
        logic [31:0] inj;
        logic [31:0] rstl;
        logic [31:0] cons;
        int          resp;
        int          drop;
        int          peak;
    } dir_t;

    dir_t dirs [8] = '{
        // single pulse, LATENCY=1: request at 5 -> response at 6
        '{1,  8, 32'h0000_0020, 32'h0, 32'h0,  32'h0000_0040, 1, 0, 1},
        // LATENCY=0: requests 3..6 -> responses 3..6, never busy
        '{0,  8, 32'h0000_0078, 32'h0, 32'h0,  32'h0000_0078, 4, 0, 0},
        // LATENCY=3: requests 10..14 -> responses 13..17, peak 3 in flight
        '{3, 20, 32'h0000_7C00, 32'h0, 32'h0,  32'h0003_E000, 5, 0, 3},
        // LATENCY=2: fail at 4, requests 5,6 -> only 8 emitted
        '{2, 10, 32'h0000_0060, 32'h10, 32'h0, 32'h0000_0100, 1, 1, 2},
        // LATENCY=4: request at 2, reset in 4..5 -> nothing ever emitted
        '{4, 10, 32'h0000_0004, 32'h0, 32'h30, 32'h0000_0000, 0, 0, 1},
        // CNT_W=4: 20 requests -> resp_count saturates at 15
        '{0, 22, 32'h001F_FFFE, 32'h0, 32'h0,  32'h001F_FFFE, 15, 0, 0},
        // LATENCY=7: fail at 2 and 3 does not stack; requests 1..4 -> 9,10,11
        '{5, 14, 32'h0000_001E, 32'hC, 32'h0,  32'h0000_0E00, 3, 1, 4},
        // LATENCY=1: fail in the cycle a response is due drops that one only
        '{1, 10, 32'h0000_0048, 32'h10, 32'h0, 32'h0000_0080, 1, 1, 1}
    };

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            ant_a[i] = 1'b0;
            en_a[i]  = 1'b1;
            inj_a[i] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_dir(input dir_t d);
        int   peak;
        logic prev_rst;
        apply_reset();
        peak     = 0;
        prev_rst = 1'b0;
        for (int c = 1; c <= d.ncyc; c++) begin
            idle_inputs();
            ant_a[d.inst] = d.ant[c];
            inj_a[d.inst] = d.inj[c];
            rst_n         = !d.rstl[c];
            @(negedge clk);
            check("dir_consequent", d.inst, cons_a[d.inst], d.cons[c]);
            if (prev_rst && !d.rstl[c]) begin
                check("dir_release_inflight", d.inst, infl_a[d.inst], 0);
                check("dir_release_state", d.inst, int'(st_a[d.inst]), int'(IDLE));
            end
            if (int'(infl_a[d.inst]) > peak) peak = int'(infl_a[d.inst]);
            prev_rst = d.rstl[c];
            @(posedge clk);
            #1;
        end
        check("dir_resp_count", d.inst, rc_a[d.inst], d.resp);
        check("dir_drop_count", d.inst, dc_a[d.inst], d.drop);
        check("dir_inflight_peak", d.inst, peak, d.peak);
    endtask

    initial begin
        idle_inputs();
        for (int t = 0; t < 8; t++) begin
            run_dir(dirs[t]);
        end

        // Random traffic on every instance, with occasional reset pulses
        // landing on responses in flight.
        apply_reset();
        repeat (4000) begin
            for (int i = 0; i < NI; i++) begin
                ant_a[i] = 1'($urandom_range(0, 1));
                en_a[i]  = ($urandom_range(0, 3) != 0);
                inj_a[i] = ($urandom_range(0, 15) == 0);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle_inputs();
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/implication_responder.md
IMPLICATION_RESPONDER -- requirements
Module: implication_responder

Interface
REQ-001 Parameter LATENCY, default 1, cycles from antecedent sample to consequent (0 = overlapping, 1 = non-overlapping, legal 0..7).
REQ-002 Parameter CNT_W, default 16, width of response and drop counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 antecedent  input  1  request sampled each posedge.
REQ-006 en  input  1  responder enable; antecedent ignored when low.
REQ-007 inject_fail  input  1  pulse; arms suppression of the next scheduled consequent.
REQ-008 consequent  output  1  response pulse.
REQ-009 busy  output  1  high while any response is in flight.
REQ-010 inflight  output  4  number of scheduled, not yet emitted responses.
REQ-011 resp_count  output  CNT_W  consequents emitted since reset.
REQ-012 drop_count  output  CNT_W  consequents suppressed since reset.

Function
REQ-013 Accepted request = antecedent && en at a posedge.
REQ-014 LATENCY=0: consequent SHALL equal accepted request combinationally in the same cycle, unless suppressed.
REQ-015 LATENCY=N>0: an accepted request at cycle k SHALL produce consequent high for exactly one cycle at cycle k+N, unless suppressed.
REQ-016 Back-to-back accepted requests SHALL produce back-to-back consequents; no merging, no loss.
REQ-017 inflight SHALL count accepted requests not yet emitted or dropped; simultaneous accept and emit leaves it unchanged; maximum value is LATENCY.
REQ-018 busy SHALL equal (inflight != 0).
REQ-019 FSM states: IDLE (inflight 0, not armed), PENDING (inflight > 0, not armed), ARMED (suppression armed).
REQ-020 IDLE->PENDING on accept; PENDING->IDLE when the last response leaves; any state->ARMED on inject_fail; ARMED->IDLE/PENDING after one response is suppressed.
REQ-021 In ARMED, the next consequent due SHALL be forced low and drop_count incremented instead of resp_count.
REQ-022 inject_fail while already ARMED SHALL not stack; one suppression only.
REQ-023 inject_fail in the same cycle a consequent is due SHALL suppress that consequent.
REQ-024 Deasserting en SHALL not cancel responses already in flight.
REQ-025 resp_count and drop_count SHALL saturate at all-ones, not wrap.

Reset
REQ-026 rst_n low SHALL immediately clear the delay line, inflight, busy, counters, and suppression, and SHALL force state IDLE.
REQ-027 consequent SHALL be 0 throughout reset, including LATENCY=0.
REQ-028 Responses in flight when reset asserts SHALL be discarded and never emitted.
REQ-029 The first accept is possible at the first posedge with rst_n high.

Configuration
REQ-030 Macro IMPLICATION_RESPONDER_SVA_EN defined: embedded concurrent assertions SHALL check antecedent&&en&&!armed |-> ##LATENCY consequent, consequent pulse width 1, inflight <= LATENCY, with cover properties on both overlapping and non-overlapping responses.
REQ-031 Macro undefined: no assertions or covers compiled; functional behaviour identical.

Structure
REQ-032 Package implication_pkg SHALL hold the FSM state enum, LATENCY_MAX = 7, and default CNT_W.
REQ-033 Sub-module resp_delay_line SHALL implement the LATENCY-deep 1-bit shift register with async clear; LATENCY=0 degenerates to a wire.
REQ-034 Counters, FSM, and suppression logic reside in implication_responder.

Verification
REQ-035 LATENCY=1, single antecedent pulse at cycle 5 -> consequent high at cycle 6 only; resp_count=1.
REQ-036 LATENCY=0, antecedent high cycles 3..6 -> consequent high cycles 3..6; resp_count=4; busy stays 0.
REQ-037 LATENCY=3, antecedent every cycle 10..14 -> consequent 13..17; inflight peaks at 3.
REQ-038 LATENCY=2, inject_fail at cycle 4, antecedent at 5 and 6 -> consequent only at 8; drop_count=1, resp_count=1.
REQ-039 LATENCY=4, antecedent at 2, rst_n low at 4 -> no consequent at 6; inflight=0 and state IDLE on release.
REQ-040 CNT_W=4, 20 accepted requests -> resp_count saturates at 15.
